// File: rtl/ttt_match_ctrl.sv
// Match sequencer in front of the tic-tac-toe board engine: arbitrates X/O
// move requests, replays accepted moves to the engine and keeps the match score.
module ttt_match_ctrl #(
  parameter int GAMES_TO_WIN = 2,
  parameter int TURN_TIMEOUT = 1000,
  parameter int CLR_CYC      = 2,
  parameter int SETTLE_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        x_req,
  input  logic [1:0]  x_row,
  input  logic [1:0]  x_col,
  input  logic        o_req,
  input  logic [1:0]  o_row,
  input  logic [1:0]  o_col,
  input  logic [17:0] eng_board,
  input  logic [1:0]  eng_winner,
  output logic        eng_rst,
  output logic [1:0]  eng_row,
  output logic [1:0]  eng_col,
  output logic        eng_enter,
  output logic        turn,
  output logic        x_ack,
  output logic        o_ack,
  output logic        x_rej,
  output logic        o_rej,
  output logic [3:0]  score_x,
  output logic [3:0]  score_o,
  output logic        match_done,
  output logic [1:0]  match_winner
);

  localparam int PMAX = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int TW   = $clog2(TURN_TIMEOUT);
  localparam logic [PW-1:0] CLR_LAST    = PW'(CLR_CYC - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TURN_LAST   = TW'(TURN_TIMEOUT - 1);
  localparam logic [3:0]    SCORE_MAX   = 4'(GAMES_TO_WIN);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_CHECK     = 3'd5,
    ST_GAME_END  = 3'd6,
    ST_MATCH_END = 3'd7
  } state_t;

  state_t          state_r;
  logic            starter_r;
  logic [TW-1:0]   tcnt_r;
  logic [PW-1:0]   pcnt_r;
  logic            cur_req_s;
  logic [1:0]      cur_row_s;
  logic [1:0]      cur_col_s;
  logic            bad_coord_s;
  logic            occupied_s;

  // Cell = row*3+col+1 packed two bits per cell; off-board coordinates read as empty.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [1:0] r,
                                         input logic [1:0] c);
    logic [1:0] v;
    case ({r, c})
      4'b0000: v = b[1:0];
      4'b0001: v = b[3:2];
      4'b0010: v = b[5:4];
      4'b0100: v = b[7:6];
      4'b0101: v = b[9:8];
      4'b0110: v = b[11:10];
      4'b1000: v = b[13:12];
      4'b1001: v = b[15:14];
      4'b1010: v = b[17:16];
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  // Select the requester whose turn it is and classify its request.
  always_comb begin
    cur_req_s = 1'b0;
    cur_row_s = 2'd0;
    cur_col_s = 2'd0;
    if (turn) begin
      cur_req_s = o_req;
      cur_row_s = o_row;
      cur_col_s = o_col;
    end else begin
      cur_req_s = x_req;
      cur_row_s = x_row;
      cur_col_s = x_col;
    end
    bad_coord_s = (cur_row_s == 2'd3) || (cur_col_s == 2'd3);
    occupied_s  = (cell_at(eng_board, cur_row_s, cur_col_s) != 2'b00);
  end

  // Match sequencing FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      starter_r    <= 1'b0;
      tcnt_r       <= '0;
      pcnt_r       <= '0;
      eng_rst      <= 1'b1;
      eng_row      <= 2'd0;
      eng_col      <= 2'd0;
      eng_enter    <= 1'b0;
      turn         <= 1'b0;
      x_ack        <= 1'b0;
      o_ack        <= 1'b0;
      x_rej        <= 1'b0;
      o_rej        <= 1'b0;
      score_x      <= 4'd0;
      score_o      <= 4'd0;
      match_done   <= 1'b0;
      match_winner <= 2'b00;
    end else begin
      eng_enter <= 1'b0;
      x_ack     <= 1'b0;
      o_ack     <= 1'b0;
      x_rej     <= 1'b0;
      o_rej     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          eng_rst <= 1'b1;
          if (start) begin
            state_r   <= ST_CLEAR;
            pcnt_r    <= '0;
            score_x   <= 4'd0;
            score_o   <= 4'd0;
            starter_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (pcnt_r == CLR_LAST) begin
            state_r <= ST_WAIT;
            eng_rst <= 1'b0;
            turn    <= starter_r;
            tcnt_r  <= '0;
          end else begin
            eng_rst <= 1'b1;
            pcnt_r  <= pcnt_r + PW'(1);
          end
        end
        ST_WAIT: begin
          // An expiring turn wins over a request arriving in the same cycle.
          if (tcnt_r == TURN_LAST) begin
            turn   <= ~turn;
            tcnt_r <= '0;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
            if (cur_req_s) begin
              if (bad_coord_s || occupied_s) begin
                x_rej <= ~turn;
                o_rej <= turn;
              end else begin
                x_ack   <= ~turn;
                o_ack   <= turn;
                eng_row <= cur_row_s;
                eng_col <= cur_col_s;
                state_r <= ST_ISSUE;
              end
            end
          end
        end
        ST_ISSUE: begin
          eng_enter <= 1'b1;
          pcnt_r    <= '0;
          state_r   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (pcnt_r == SETTLE_LAST) begin
            state_r <= ST_CHECK;
          end else begin
            pcnt_r <= pcnt_r + PW'(1);
          end
        end
        ST_CHECK: begin
          case (eng_winner)
            2'b00: begin
              turn    <= ~turn;
              tcnt_r  <= '0;
              state_r <= ST_WAIT;
            end
            2'b01: begin
              if (score_x < SCORE_MAX) score_x <= score_x + 4'd1;
              state_r <= ST_GAME_END;
            end
            2'b10: begin
              if (score_o < SCORE_MAX) score_o <= score_o + 4'd1;
              state_r <= ST_GAME_END;
            end
            default: state_r <= ST_GAME_END;
          endcase
        end
        ST_GAME_END: begin
          if ((score_x == SCORE_MAX) || (score_o == SCORE_MAX)) begin
            state_r      <= ST_MATCH_END;
            match_done   <= 1'b1;
            match_winner <= (score_x == SCORE_MAX) ? 2'b01 : 2'b10;
            eng_rst      <= 1'b0;
          end else begin
            starter_r <= ~starter_r;
            eng_rst   <= 1'b1;
            pcnt_r    <= '0;
            state_r   <= ST_CLEAR;
          end
        end
        ST_MATCH_END: begin
          // Board is left unreset so the final position stays visible.
          if (start) begin
            state_r      <= ST_CLEAR;
            eng_rst      <= 1'b1;
            pcnt_r       <= '0;
            score_x      <= 4'd0;
            score_o      <= 4'd0;
            starter_r    <= 1'b0;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
          end else begin
            eng_rst    <= 1'b0;
            match_done <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          eng_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_match_ctrl.sv
// Random-stimulus bench for ttt_match_ctrl: a program-style match model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_ttt_match_ctrl;

  localparam int G  = 2;
  localparam int TO = 8;
  localparam int CC = 2;
  localparam int SC = 2;

  localparam logic [3:0] K_XACK  = 4'd1;
  localparam logic [3:0] K_OACK  = 4'd2;
  localparam logic [3:0] K_XREJ  = 4'd3;
  localparam logic [3:0] K_OREJ  = 4'd4;
  localparam logic [3:0] K_ENTER = 4'd5;
  localparam logic [3:0] K_CLR   = 4'd6;
  localparam logic [3:0] K_MATCH = 4'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        x_req = 1'b0;
  logic [1:0]  x_row = 2'd0;
  logic [1:0]  x_col = 2'd0;
  logic        o_req = 1'b0;
  logic [1:0]  o_row = 2'd0;
  logic [1:0]  o_col = 2'd0;
  logic [17:0] board = 18'd0;
  logic [1:0]  eng_winner;
  logic        eng_rst;
  logic [1:0]  eng_row;
  logic [1:0]  eng_col;
  logic        eng_enter;
  logic        turn;
  logic        x_ack, o_ack, x_rej, o_rej;
  logic [3:0]  score_x, score_o;
  logic        match_done;
  logic [1:0]  match_winner;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] sb_q[$];
  logic        m_mover = 1'b0;
  bit          m_ab = 1'b0;
  logic        rst_q = 1'b1;

  ttt_match_ctrl #(.GAMES_TO_WIN(G), .TURN_TIMEOUT(TO), .CLR_CYC(CC), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_req(x_req), .x_row(x_row), .x_col(x_col),
    .o_req(o_req), .o_row(o_row), .o_col(o_col),
    .eng_board(board), .eng_winner(eng_winner),
    .eng_rst(eng_rst), .eng_row(eng_row), .eng_col(eng_col), .eng_enter(eng_enter),
    .turn(turn), .x_ack(x_ack), .o_ack(o_ack), .x_rej(x_rej), .o_rej(o_rej),
    .score_x(score_x), .score_o(score_o),
    .match_done(match_done), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [3:0] k, input logic t, input logic [1:0] r,
                                     input logic [1:0] c, input logic [3:0] sx,
                                     input logic [3:0] so, input logic [1:0] w);
    return {13'd0, k, t, r, c, sx, so, w};
  endfunction

  function automatic logic [1:0] cl(input logic [17:0] b, input int i);
    return b[2*i +: 2];
  endfunction

  // Engine judgement: any completed line wins, a full board without one is a draw.
  function automatic logic [1:0] judge(input logic [17:0] b);
    logic [1:0] res;
    bit full;
    res = 2'b00;
    full = 1'b1;
    for (int m = 1; m <= 2; m++) begin
      for (int i = 0; i < 3; i++) begin
        if (cl(b, 3*i) == m && cl(b, 3*i+1) == m && cl(b, 3*i+2) == m) res = 2'(m);
        if (cl(b, i) == m && cl(b, i+3) == m && cl(b, i+6) == m) res = 2'(m);
      end
      if (cl(b, 0) == m && cl(b, 4) == m && cl(b, 8) == m) res = 2'(m);
      if (cl(b, 2) == m && cl(b, 4) == m && cl(b, 6) == m) res = 2'(m);
    end
    for (int i = 0; i < 9; i++) if (cl(b, i) == 2'b00) full = 1'b0;
    if (res == 2'b00 && full) res = 2'b11;
    return res;
  endfunction

  assign eng_winner = judge(board);

  // Board engine model: cleared by eng_rst, marks the mover's cell on eng_enter.
  always @(posedge clk) begin
    if (eng_rst) board <= 18'd0;
    else if (eng_enter && eng_row != 2'd3 && eng_col != 2'd3)
      board[2*(3*int'(eng_row)+int'(eng_col)) +: 2] <= m_mover ? 2'b10 : 2'b01;
  end

  // Reset as the DUT saw it at the last active edge.
  always @(posedge clk) rst_q <= rst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic expect_ev(input string nm, input logic [31:0] act);
    logic [31:0] exp;
    n_chk++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: DUT produced %0h, required nothing", nm, act);
    end else begin
      exp = sb_q.pop_front();
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic drive_rand();
    x_req = ($urandom_range(3) == 0);
    x_row = 2'($urandom_range(3));
    x_col = 2'($urandom_range(3));
    o_req = ($urandom_range(3) == 0);
    o_row = 2'($urandom_range(3));
    o_col = 2'($urandom_range(3));
    start = ($urandom_range(63) == 0);
  endtask

  task automatic m_step();
    @(posedge clk);
    if (rst) m_ab = 1'b1;
  endtask

  // Reference: the match written as a program of waits, one pass per match.
  task automatic run_model();
    int sx, so, tcnt;
    logic starter, t, rq, bad;
    logic [1:0] rr, cc, w;
    bit over;
    forever begin
      do begin
        m_step();
        if (m_ab) return;
      end while (!start);
      sx = 0; so = 0; starter = 1'b0; over = 1'b0;
      while (!over) begin
        repeat (CC) begin m_step(); if (m_ab) return; end
        t = starter;
        sb_q.push_back(pk(K_CLR, t, 2'd0, 2'd0, 4'(sx), 4'(so), 2'd0));
        tcnt = 0;
        w = 2'b00;
        while (w == 2'b00) begin
          m_step();
          if (m_ab) return;
          if (tcnt == TO - 1) begin
            t = ~t;
            tcnt = 0;
          end else begin
            tcnt++;
            rq = t ? o_req : x_req;
            rr = t ? o_row : x_row;
            cc = t ? o_col : x_col;
            if (rq) begin
              if (rr == 2'd3 || cc == 2'd3) bad = 1'b1;
              else bad = (cl(board, 3*int'(rr)+int'(cc)) != 2'b00);
              if (bad) begin
                sb_q.push_back(pk(t ? K_OREJ : K_XREJ, t, 2'd0, 2'd0, 4'd0, 4'd0, 2'd0));
              end else begin
                sb_q.push_back(pk(t ? K_OACK : K_XACK, t, rr, cc, 4'd0, 4'd0, 2'd0));
                sb_q.push_back(pk(K_ENTER, 1'b0, rr, cc, 4'd0, 4'd0, 2'd0));
                m_mover = t;
                // issue cycle, SC settle cycles, then the result is read
                repeat (SC + 2) begin m_step(); if (m_ab) return; end
                w = eng_winner;
                if (w == 2'b00) begin
                  t = ~t;
                  tcnt = 0;
                end
              end
            end
          end
        end
        if (w == 2'b01 && sx < G) sx++;
        if (w == 2'b10 && so < G) so++;
        m_step();
        if (m_ab) return;
        if (sx == G || so == G) begin
          sb_q.push_back(pk(K_MATCH, 1'b0, 2'd0, 2'd0, 4'(sx), 4'(so),
                            (sx == G) ? 2'b01 : 2'b10));
          over = 1'b1;
        end else begin
          starter = ~starter;
        end
      end
    end
  endtask

  initial begin
    forever begin
      m_ab = 1'b0;
      run_model();
    end
  end

  // Monitor: every DUT pulse or phase edge consumes one scoreboard entry.
  initial begin
    logic prev_er, prev_md;
    bit rise_seen;
    int clr_len;
    prev_er = 1'b1; prev_md = 1'b0; rise_seen = 1'b0; clr_len = 0;
    forever begin
      @(negedge clk);
      if (x_ack === 1'b1) expect_ev("x_ack", pk(K_XACK, turn, eng_row, eng_col, 4'd0, 4'd0, 2'd0));
      if (o_ack === 1'b1) expect_ev("o_ack", pk(K_OACK, turn, eng_row, eng_col, 4'd0, 4'd0, 2'd0));
      if (x_rej === 1'b1) expect_ev("x_rej", pk(K_XREJ, turn, 2'd0, 2'd0, 4'd0, 4'd0, 2'd0));
      if (o_rej === 1'b1) expect_ev("o_rej", pk(K_OREJ, turn, 2'd0, 2'd0, 4'd0, 4'd0, 2'd0));
      if (eng_enter === 1'b1)
        expect_ev("eng_enter", pk(K_ENTER, 1'b0, eng_row, eng_col, 4'd0, 4'd0, 2'd0));
      if (rst_q) begin
        rise_seen = 1'b0;
        clr_len = 0;
      end else begin
        if (eng_rst === 1'b1 && prev_er == 1'b0) begin
          rise_seen = 1'b1;
          clr_len = 1;
        end else if (eng_rst === 1'b1) begin
          clr_len++;
        end else if (prev_er == 1'b1) begin
          expect_ev("clear_end", pk(K_CLR, turn, 2'd0, 2'd0, score_x, score_o, 2'd0));
          if (rise_seen) chk("clear_len", clr_len, CC);
          rise_seen = 1'b0;
        end
        if (match_done === 1'b1 && prev_md == 1'b0)
          expect_ev("match_end", pk(K_MATCH, eng_rst, 2'd0, 2'd0, score_x, score_o, match_winner));
      end
      prev_er = eng_rst;
      prev_md = match_done;
    end
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_eng_enter", eng_enter, 0);
    chk("rst_turn", turn, 0);
    chk("rst_eng_pos", {eng_row, eng_col}, 0);
    chk("rst_pulses", {x_ack, o_ack, x_rej, o_rej}, 0);
    chk("rst_scores", {score_x, score_o}, 0);
    chk("rst_match", {match_done, match_winner}, 0);
    rst = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      drive_rand();
    end
    // Abort a game while it is settling after a move.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (eng_enter === 1'b1) found = 1'b1;
      else drive_rand();
    end
    chk("settle_reached", found, 1);
    rst = 1'b1;
    x_req = 1'b0;
    o_req = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_eng_rst", eng_rst, 1);
    chk("midrst_eng_enter", eng_enter, 0);
    chk("midrst_scores", {score_x, score_o}, 0);
    chk("midrst_turn", turn, 0);
    chk("midrst_match", {match_done, match_winner}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_no_enter", {eng_enter, eng_rst}, 2'b01);
    end
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
